// File: rtl/clock_div_pkg.sv
// Shared constants and channel state encoding
// for the multi-channel clock divider.
package clock_div_pkg;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_DIV   = 4095;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, active and
// shadow divisor, registered tick/clk_out.
module clock_divider_channel
    import clock_div_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             clk_out,
    output logic             pending
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_shd;
    ch_state_e        state;
    logic             term;

    always_comb begin
        state = (en && div_act != '0) ? ST_RUN : ST_IDLE;
        term  = (state == ST_RUN) && (cnt == div_act);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            div_act <= DIV_RST;
            div_shd <= DIV_RST;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            pending <= 1'b0;
        end else if (sync) begin
            cnt     <= '0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            pending <= 1'b0;
            if (load) begin
                div_act <= div_in;
                div_shd <= div_in;
            end else if (pending) begin
                div_act <= div_shd;
            end
        end else begin
            tick <= term;
            unique case (state)
                ST_IDLE: begin
                    if (load) begin
                        div_act <= div_in;
                        div_shd <= div_in;
                        pending <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (term) begin
                        cnt     <= '0;
                        clk_out <= ~clk_out;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                    // Mid-period loads wait in the shadow so the
                    // running period always finishes on the old divisor.
                    if (load && !term) begin
                        div_shd <= div_in;
                        pending <= 1'b1;
                    end else if (load) begin
                        div_act <= div_in;
                        div_shd <= div_in;
                        pending <= 1'b0;
                    end else if (term && pending) begin
                        div_act <= div_shd;
                        pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable tick generator:
// CHANNELS independent dividers sharing sync.
module clock_divider_multi
    import clock_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic                      sync,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] div_in,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS-1:0]       clk_out,
    output logic [CHANNELS-1:0]       pending
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        clock_divider_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .load    (load[i]),
            .div_in  (div_in[i*WIDTH +: WIDTH]),
            .tick    (tick[i]),
            .clk_out (clk_out[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed timing
// checks plus random traffic vs a period model.
module tb_clock_divider_multi;

    localparam int CH = 4;
    localparam int W  = 12;
    localparam int DD = 4095;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CH-1:0]   en = '0;
    logic            sync = 1'b0;
    logic [CH-1:0]   load = '0;
    logic [CH*W-1:0] div_in = '0;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   clk_out;
    logic [CH-1:0]   pending;

    int n_chk = 0;
    int n_pass = 0;

    // Model: phase within the current period, period length,
    // waiting period length (0 = none), and observed outputs.
    int m_ph[CH];
    int m_per[CH];
    int m_next[CH];
    bit m_tick[CH];
    bit m_co[CH];

    clock_divider_multi #(
        .CHANNELS    (CH),
        .WIDTH       (W),
        .DEFAULT_DIV (DD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .load    (load),
        .div_in  (div_in),
        .tick    (tick),
        .clk_out (clk_out),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            m_ph[c]   = 0;
            m_per[c]  = DD + 1;
            m_next[c] = 0;
            m_tick[c] = 0;
            m_co[c]   = 0;
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < CH; c++) begin
            int  nd;
            bit  live;
            bit  ends;
            nd = int'(div_in[c*W +: W]) + 1;
            if (sync) begin
                m_tick[c] = 0;
                m_co[c]   = 0;
                m_ph[c]   = 0;
                if (load[c]) m_per[c] = nd;
                else if (m_next[c] != 0) m_per[c] = m_next[c];
                m_next[c] = 0;
            end else begin
                live = en[c] && (m_per[c] > 1);
                ends = live && (m_ph[c] + 1 == m_per[c]);
                m_tick[c] = ends;
                if (live) m_ph[c] = ends ? 0 : m_ph[c] + 1;
                if (ends) m_co[c] = !m_co[c];
                if (load[c] && live && !ends) begin
                    m_next[c] = nd;
                end else if (load[c]) begin
                    m_per[c]  = nd;
                    m_next[c] = 0;
                end else if (ends && m_next[c] != 0) begin
                    m_per[c]  = m_next[c];
                    m_next[c] = 0;
                end
            end
        end
    endfunction

    task automatic compare_model();
        logic [CH-1:0] et, ec, ep;
        for (int c = 0; c < CH; c++) begin
            et[c] = m_tick[c];
            ec[c] = m_co[c];
            ep[c] = (m_next[c] != 0);
        end
        check("m_tick", 32'(tick), 32'(et));
        check("m_clk_out", 32'(clk_out), 32'(ec));
        check("m_pending", 32'(pending), 32'(ep));
    endtask

    // One clock edge with the currently driven inputs.
    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare_model();
        load = '0;
        sync = 1'b0;
    endtask

    task automatic do_reset();
        en   = '0;
        load = '0;
        sync = 1'b0;
        rst  = 1'b0;
        #3;
        model_reset();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic idle_load(input int c, input int d);
        div_in[c*W +: W] = W'(d);
        load[c] = 1'b1;
        step();
    endtask

    initial begin
        do_reset();

        // Defaults: ticks at 4096 and 8192.
        en = '1;
        for (int n = 1; n <= 8200; n++) begin
            step();
            if (n == 4095 || n == 8192)
                check("def_co_lo", 32'(clk_out[0]), 32'd0);
            if (n == 4096 || n == 8191)
                check("def_co_hi", 32'(clk_out[0]), 32'd1);
            if (n == 4096 || n == 8192)
                check("def_tick", 32'(tick[0]), 32'd1);
        end

        // div=3 and div=0 side by side.
        do_reset();
        idle_load(0, 3);
        idle_load(1, 0);
        en = 4'b0011;
        for (int n = 1; n <= 13; n++) begin
            step();
            check("d3_tick", 32'(tick[0]), 32'(n % 4 == 0));
            check("d0_tick", 32'(tick[1]), 32'd0);
            check("d0_co", 32'(clk_out[1]), 32'd0);
        end

        // Mid-period reload from 9 to 2.
        do_reset();
        idle_load(0, 9);
        en = 4'b0001;
        for (int n = 1; n <= 17; n++) begin
            if (n == 6) begin
                div_in[0 +: W] = W'(2);
                load[0] = 1'b1;
            end
            step();
            check("rl_tick", 32'(tick[0]),
                  32'(n == 10 || n == 13 || n == 16));
            if (n >= 6 && n <= 10)
                check("rl_pend", 32'(pending[0]), 32'(n != 10));
        end

        // Sync after random drift.
        do_reset();
        idle_load(0, 4);
        idle_load(1, 6);
        en = 4'b0011;
        for (int k = $urandom_range(10, 40); k > 0; k--) step();
        sync = 1'b1;
        step();
        check("sy_co", 32'(clk_out[1:0]), 32'd0);
        check("sy_tick", 32'(tick[1:0]), 32'd0);
        for (int n = 1; n <= 8; n++) begin
            step();
            check("sy_t0", 32'(tick[0]), 32'(n == 5));
            check("sy_t1", 32'(tick[1]), 32'(n == 7));
        end

        // Load coincident with terminal.
        do_reset();
        idle_load(0, 3);
        en = 4'b0001;
        for (int n = 1; n <= 11; n++) begin
            if (n == 4) begin
                div_in[0 +: W] = W'(5);
                load[0] = 1'b1;
            end
            step();
            check("lt_tick", 32'(tick[0]), 32'(n == 4 || n == 10));
            check("lt_pend", 32'(pending[0]), 32'd0);
        end

        // Sync plus load coincident with terminal.
        do_reset();
        idle_load(0, 3);
        en = 4'b0001;
        for (int n = 1; n <= 8; n++) begin
            if (n == 4) begin
                div_in[0 +: W] = W'(2);
                load[0] = 1'b1;
                sync = 1'b1;
            end
            step();
            check("st_tick", 32'(tick[0]), 32'(n == 7));
            if (n == 4) begin
                check("st_pend", 32'(pending[0]), 32'd0);
                check("st_co", 32'(clk_out[0]), 32'd0);
            end
        end

        // Asynchronous reset with clk_out=1, pending=1.
        do_reset();
        idle_load(0, 9);
        en = 4'b0001;
        for (int n = 1; n <= 13; n++) begin
            if (n == 13) begin
                div_in[0 +: W] = W'(2);
                load[0] = 1'b1;
            end
            step();
        end
        check("ar_pre_co", 32'(clk_out[0]), 32'd1);
        check("ar_pre_pend", 32'(pending[0]), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("ar_tick", 32'(tick), 32'd0);
        check("ar_co", 32'(clk_out), 32'd0);
        check("ar_pend", 32'(pending), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int n = 1; n <= 4097; n++) begin
            step();
            if (n >= 4095)
                check("ar_tick_def", 32'(tick[0]), 32'(n == 4096));
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < CH; c++)
            idle_load(c, $urandom_range(1, 9));
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < CH; c++) begin
                en[c]   = ($urandom_range(0, 9) != 0);
                load[c] = ($urandom_range(0, 19) == 0);
                div_in[c*W +: W] = W'($urandom_range(0, 9));
            end
            sync = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
